not_gate_unit: RTL and testbench
================================

# not_gate_unit

Inverter block with a combinational path and a clocked, enable-gated registered path. The combinational output Y is the bitwise complement of input A at all times, regardless of clock or reset. A registered copy of the inverted value, a valid strobe and a saturating input-toggle counter support synchronous consumers and activity monitoring. The block is a leaf cell used wherever an inverted bus is needed in the datapath.

## Interface
- WIDTH, 1, bit width of A, Y and Y_q
- CNT_W, 16, width of toggle_cnt
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; one clock; asynchronous active-low reset
- A  input  WIDTH  data to invert
- Y  output  WIDTH  combinational ~A
- en  input  1  sample enable for registered path
- clr  input  1  synchronous clear of toggle_cnt
- Y_q  output  WIDTH  registered ~A
- vld  output  1  Y_q updated this cycle
- toggle_cnt  output  CNT_W  count of enabled samples where A differed from the previous sample

## Operation
- Y = ~A, bitwise, purely combinational, with no dependence on clk, rst_n, en or clr.
- Internal register A_q holds the last enabled sample of A.
- On a rising clk edge with en=1:
  - A_q <= A and Y_q <= ~A.
  - vld <= 1.
  - If A != A_q (old value) and toggle_cnt is below its maximum, toggle_cnt increments by 1.
- On a rising clk edge with en=0:
  - A_q and Y_q hold.
  - vld <= 0.
  - toggle_cnt holds.
- toggle_cnt saturates at 2^CNT_W-1 and never wraps.
- clr=1 forces toggle_cnt <= 0 on that edge. It takes priority over an increment on the same edge and does not affect A_q, Y_q or vld.
- Any multi-bit difference between A and A_q counts as one toggle.

## Timing
- Y: zero-cycle latency; valid one propagation delay after A changes.
- Y_q, vld, toggle_cnt: one-cycle latency from the en=1 edge.
- Reset (rst_n=0, asynchronous, effective immediately and held while low):
  - A_q=0, Y_q=all ones, vld=0, toggle_cnt=0.
  - Y keeps following ~A during reset.
- Release: the first rising edge with rst_n=1 acts normally. A_q starts at 0, so an enabled sample of a non-zero A counts as a toggle.
- Reset asserted mid-operation discards the count and the registered value immediately, without waiting for a clock edge.
- No handshake backpressure: vld is a single-cycle strobe per enabled edge and stays high on consecutive en=1 cycles.

## Test plan
- Combinational path, WIDTH=1:
  - A=0 then wait 5 ns -> Y=1.
  - A=1 then wait 5 ns -> Y=0.
  - Also check both values with rst_n held low.
- Registered path, WIDTH=8:
  - en=1, A=8'h3C at one edge -> next cycle Y_q=8'hC3, vld=1.
  - en=0, A=8'hFF -> Y_q stays 8'hC3, vld=0, Y=8'h00.
- Toggle counting: en=1 with A sequence 0,1,1,0,1 after reset -> toggle_cnt=3 (the first 0 matches A_q=0).
- Saturation, CNT_W=4: 20 alternating enabled samples -> toggle_cnt stops at 15.
- Clear priority: clr=1 on an edge where A toggles with en=1 -> toggle_cnt=0, Y_q updated, vld=1.
- Asynchronous reset mid-run: count=5, Y_q=8'h0F, then drop rst_n between edges -> immediately toggle_cnt=0, Y_q=8'hFF, vld=0, Y=~A unchanged.

Source files
------------

// File: rtl/not_gate_unit_if.sv
// Signal bundle for not_gate_unit: data in, inverted outputs, registered copy and activity count.
// The driver of A/en/clr uses master; the inverter cell uses slave.
interface not_gate_unit_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] Y;
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] Y_q;
    logic             vld;
    logic [CNT_W-1:0] toggle_cnt;

    modport master (
        output A, en, clr,
        input  Y, Y_q, vld, toggle_cnt
    );

    modport slave (
        input  A, en, clr,
        output Y, Y_q, vld, toggle_cnt
    );
endinterface

// File: rtl/not_gate_unit.sv
// Inverter leaf cell: combinational ~A, an enable-gated registered ~A with valid strobe,
// and a saturating counter of enabled samples that differ from the previous enabled sample.
module not_gate_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    not_gate_unit_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] a_q_reg;
    logic [WIDTH-1:0] y_q_reg;
    logic             vld_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             toggled;

    // Pure combinational inversion, independent of clock and reset.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_inv
            assign bus.Y[gi] = ~bus.A[gi];
        end
    endgenerate

    assign toggled = bus.en && (bus.A != a_q_reg);

    always_comb begin
        cnt_next = cnt_reg;
        if (bus.clr) begin
            cnt_next = '0;
        end else if (toggled && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q_reg <= '0;
            y_q_reg <= '1;
            vld_reg <= 1'b0;
            cnt_reg <= '0;
        end else begin
            vld_reg <= bus.en;
            cnt_reg <= cnt_next;
            if (bus.en) begin
                a_q_reg <= bus.A;
                y_q_reg <= ~bus.A;
            end
        end
    end

    assign bus.Y_q        = y_q_reg;
    assign bus.vld        = vld_reg;
    assign bus.toggle_cnt = cnt_reg;
endmodule

// File: tb/tb_not_gate_unit.sv
// Bench for not_gate_unit: three instances (8-bit/16-bit count, 1-bit, 8-bit/4-bit count)
// checked against an arithmetic reference model every cycle plus directed vector tables.
module tb_not_gate_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    not_gate_unit_if #(.WIDTH(1), .CNT_W(16)) if1 ();
    not_gate_unit_if #(.WIDTH(8), .CNT_W(16)) if8 ();
    not_gate_unit_if #(.WIDTH(8), .CNT_W(4))  ifs ();

    not_gate_unit #(.WIDTH(1), .CNT_W(16)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    not_gate_unit #(.WIDTH(8), .CNT_W(16)) u_w8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    not_gate_unit #(.WIDTH(8), .CNT_W(4))  u_sat (.clk(clk), .rst_n(rst_n), .bus(ifs));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a_q;
        int y_q;
        bit vld;
        int cnt;
    } model_t;

    typedef struct {
        logic [7:0] a;
        bit         en;
        bit         clr;
        logic [7:0] yq;
        bit         vld;
        int         cnt;
    } vec_t;

    model_t m1, m8, ms;
    vec_t   vecs[10];

    function automatic model_t model_reset(int w);
        model_t n;
        n.a_q = 0;
        n.y_q = (1 << w) - 1;
        n.vld = 1'b0;
        n.cnt = 0;
        return n;
    endfunction

    // Behaviour stated as rules: value sampled on en, complement by subtraction from all-ones,
    // count grows on a change of sample and is clipped at the maximum.
    function automatic model_t model_step(model_t m, int a, bit en, bit clr, int w, int cmax);
        model_t n = m;
        n.vld = en;
        if (en) begin
            n.a_q = a;
            n.y_q = ((1 << w) - 1) - a;
        end
        if (clr) n.cnt = 0;
        else if (en && a != m.a_q) n.cnt = (m.cnt + 1 > cmax) ? cmax : m.cnt + 1;
        return n;
    endfunction

    task automatic check(string name, logic [31:0] act, int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        check("w1_y",    32'(if1.Y),          1 - int'(if1.A));
        check("w1_yq",   32'(if1.Y_q),        m1.y_q);
        check("w1_vld",  32'(if1.vld),        int'(m1.vld));
        check("w1_cnt",  32'(if1.toggle_cnt), m1.cnt);
        check("w8_y",    32'(if8.Y),          255 - int'(if8.A));
        check("w8_yq",   32'(if8.Y_q),        m8.y_q);
        check("w8_vld",  32'(if8.vld),        int'(m8.vld));
        check("w8_cnt",  32'(if8.toggle_cnt), m8.cnt);
        check("sat_y",   32'(ifs.Y),          255 - int'(ifs.A));
        check("sat_yq",  32'(ifs.Y_q),        ms.y_q);
        check("sat_vld", 32'(ifs.vld),        int'(ms.vld));
        check("sat_cnt", 32'(ifs.toggle_cnt), ms.cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m1 = model_step(m1, int'(if1.A), if1.en, if1.clr, 1, 65535);
        m8 = model_step(m8, int'(if8.A), if8.en, if8.clr, 8, 65535);
        ms = model_step(ms, int'(ifs.A), ifs.en, ifs.clr, 8, 15);
        compare_all();
    endtask

    task automatic models_reset();
        m1 = model_reset(1);
        m8 = model_reset(8);
        ms = model_reset(8);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        if1.A = '0; if1.en = 1'b0; if1.clr = 1'b0;
        if8.A = '0; if8.en = 1'b0; if8.clr = 1'b0;
        ifs.A = '0; ifs.en = 1'b0; ifs.clr = 1'b0;
        models_reset();

        vecs[0] = '{8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 0};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 8'hFE, 1'b1, 1};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 8'hFE, 1'b1, 1};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 2};
        vecs[4] = '{8'h01, 1'b1, 1'b0, 8'hFE, 1'b1, 3};
        vecs[5] = '{8'h3C, 1'b1, 1'b0, 8'hC3, 1'b1, 4};
        vecs[6] = '{8'hFF, 1'b0, 1'b0, 8'hC3, 1'b0, 4};
        vecs[7] = '{8'h55, 1'b1, 1'b1, 8'hAA, 1'b1, 0};
        vecs[8] = '{8'h55, 1'b1, 1'b0, 8'hAA, 1'b1, 0};
        vecs[9] = '{8'hF0, 1'b1, 1'b0, 8'h0F, 1'b1, 1};

        // Combinational path and reset state while rst_n is held low.
        #2;
        if1.A = 1'b0; #5;
        check("comb_y_a0_rst", 32'(if1.Y), 1);
        if1.A = 1'b1; #5;
        check("comb_y_a1_rst", 32'(if1.Y), 0);
        compare_all();
        check("rst_w8_yq", 32'(if8.Y_q), 255);
        check("rst_w8_cnt", 32'(if8.toggle_cnt), 0);
        if1.A = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("comb_y_a0", 32'(if1.Y), 1);
        if1.A = 1'b1; #5;
        check("comb_y_a1", 32'(if1.Y), 0);
        if1.A = 1'b0;

        // Directed vector table on the 8-bit instance.
        for (int i = 0; i < 10; i++) begin
            if8.A = vecs[i].a; if8.en = vecs[i].en; if8.clr = vecs[i].clr;
            tick();
            check($sformatf("tbl%0d_yq", i),  32'(if8.Y_q),        int'(vecs[i].yq));
            check($sformatf("tbl%0d_vld", i), 32'(if8.vld),        int'(vecs[i].vld));
            check($sformatf("tbl%0d_cnt", i), 32'(if8.toggle_cnt), vecs[i].cnt);
            check($sformatf("tbl%0d_y", i),   32'(if8.Y),          255 - int'(vecs[i].a));
        end

        // Build count 5 with Y_q=0F, then drop reset between edges.
        for (int i = 0; i < 4; i++) begin
            if8.A = (i % 2 == 0) ? 8'h0F : 8'hF0;
            tick();
        end
        check("pre_rst_cnt", 32'(if8.toggle_cnt), 5);
        check("pre_rst_yq", 32'(if8.Y_q), 8'h0F);
        #2;
        rst_n = 1'b0;
        #1;
        models_reset();
        check("async_cnt", 32'(if8.toggle_cnt), 0);
        check("async_yq", 32'(if8.Y_q), 8'hFF);
        check("async_vld", 32'(if8.vld), 0);
        check("async_y", 32'(if8.Y), 8'h0F);
        compare_all();
        rst_n = 1'b1;
        if8.en = 1'b0;

        // Saturation on the 4-bit counter: 20 alternating enabled samples.
        ifs.en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ifs.A = (i % 2 == 0) ? 8'h01 : 8'h00;
            tick();
        end
        check("sat_final", 32'(ifs.toggle_cnt), 15);
        ifs.en = 1'b0;

        // Randomized traffic on all instances, with an occasional mid-cycle reset.
        for (int i = 0; i < 400; i++) begin
            if1.A   = 1'($urandom_range(0, 1));
            if1.en  = ($urandom_range(0, 3) != 0);
            if1.clr = ($urandom_range(0, 15) == 0);
            if8.A   = 8'($urandom_range(0, 3) == 0 ? if8.A : 8'($urandom_range(0, 255)));
            if8.en  = ($urandom_range(0, 3) != 0);
            if8.clr = ($urandom_range(0, 31) == 0);
            ifs.A   = 8'($urandom_range(0, 255));
            ifs.en  = ($urandom_range(0, 3) != 0);
            ifs.clr = ($urandom_range(0, 63) == 0);
            tick();
            if (i % 97 == 50) begin
                #2;
                rst_n = 1'b0;
                #1;
                models_reset();
                compare_all();
                rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
